uart_rx_8n1: RTL and testbench



---
 rtl/uart_rx_8n1.sv | 128 ++++++++++++
 tb/tb_uart_rx_8n1.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: a 2-flop synchronizer, a centre-sampling bit FSM and a
// single-entry valid/ready output holding register with frame/overrun pulses.
`timescale 1ns/1ps
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          rx_s;
  logic          bit_end;
  logic          half_end;

  assign rx_s     = sync2_q;
  assign bit_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign half_end = (cnt_q == CW'(HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rx_s) state_d = START;
      START:     if (half_end) state_d = rx_s ? IDLE : DATA;
      DATA:      if (bit_end && idx_q == 3'd7) state_d = STOP;
      STOP:      if (bit_end) state_d = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    // An accepted byte leaves unless a new one lands in the same cycle below.
    rx_valid_d  = rx_valid_q & ~rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      START: if (half_end) idx_d = 3'd0;
      DATA: begin
        if (bit_end) begin
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          cnt_d          = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Idle-type states hold the counter at zero so it never wraps while waiting.
    if (state_d != state_q || state_q == IDLE || state_q == WAIT_HIGH) cnt_d = '0;
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: time-based serial driver, expected-byte queue and a
// negedge monitor that pops and compares on every accepted handshake.
`timescale 1ns/1ps
module tb_uart_rx_8n1;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         checks;
  int         failures;
  int         cyc;
  int         fall_cyc;
  int         last_rise;
  int         fe_cnt;
  int         ov_cnt;
  logic       prev_valid;
  logic [7:0] exp_q[$];

  uart_rx_8n1 #(.CLKS_PER_BIT(100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Frame starts 1 ns after a clock edge; the line is left at the stop level.
  task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_v);
    @(posedge clk);
    #1;
    rx       = 1'b0;
    fall_cyc = cyc;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_v;
    #(bit_ns);
  endtask

  task automatic expect_byte(input logic [7:0] b, input int bit_ns);
    exp_q.push_back(b);
    send_byte(b, bit_ns, 1'b1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted byte must be the oldest outstanding expectation.
  initial begin
    prev_valid = 1'b0;
    last_rise  = -1;
    forever begin
      @(negedge clk);
      if (rx_valid && !prev_valid) last_rise = cyc;
      prev_valid = rx_valid;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err || overrun) chk("err_exclusive", int'(frame_err & overrun), 0);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h expected none", rx_data);
        end else begin
          chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int fe0;
    int ov0;
    logic [7:0] b;
    checks   = 0;
    failures = 0;
    fe_cnt   = 0;
    ov_cnt   = 0;
    fall_cyc = 0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;
    cycles(5);
    chk("reset_valid", int'(rx_valid), 0);
    chk("reset_data", int'(rx_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    cycles(5);

    // Single byte and its latency from the falling edge.
    rx_ready = 1'b1;
    expect_byte(8'h41, 1000);
    chk("latency_0x41", last_rise - fall_cyc, 953);
    cycles(5);
    chk("busy_after_0x41", int'(busy), 0);
    chk("no_err_0x41", fe_cnt + ov_cnt, 0);

    // Short low glitch is rejected at the start-bit centre.
    @(posedge clk);
    #1;
    rx = 1'b0;
    #300;
    rx = 1'b1;
    cycles(10);
    chk("glitch_busy", int'(busy), 1);
    cycles(100);
    chk("glitch_idle", int'(busy), 0);
    chk("glitch_no_fe", fe_cnt, 0);
    expect_byte(8'h5A, 1000);

    // Stop bit low followed by a held break.
    fe0 = fe_cnt;
    send_byte(8'h55, 1000, 1'b0);
    #4800;
    chk("break_busy", int'(busy), 1);
    chk("break_frame_err", fe_cnt - fe0, 1);
    rx = 1'b1;
    cycles(10);
    chk("break_idle", int'(busy), 0);
    expect_byte(8'hA3, 1000);

    // Overrun: second byte dropped while the first is held.
    cycles(20);
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1000, 1'b1);
    send_byte(8'h34, 1000, 1'b1);
    cycles(20);
    chk("held_valid", int'(rx_valid), 1);
    chk("held_data", int'(rx_data), 8'h12);
    chk("overrun_pulse", ov_cnt - ov0, 1);
    rx_ready = 1'b1;
    cycles(1);
    chk("valid_falls", int'(rx_valid), 0);

    // Asynchronous reset during data bit 4.
    fork
      send_byte(8'hFF, 1000, 1'b1);
      begin
        #5500;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_data", int'(rx_data), 0);
        chk("midreset_valid", int'(rx_valid), 0);
        #19;
        rst_n = 1'b1;
      end
    join
    cycles(20);
    chk("post_reset_idle", int'(busy), 0);
    expect_byte(8'h0F, 1000);

    // Baud mismatch at -3% and +3%.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    expect_byte(8'hC3, 970);
    cycles(10);
    expect_byte(8'hC3, 1030);
    cycles(10);
    chk("baud_no_err", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Random bytes, rates within tolerance and random idle gaps.
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom_range(0, 255));
      expect_byte(b, int'($urandom_range(980, 1020)));
      #($urandom_range(0, 3000));
    end

    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("total_frame_err", fe_cnt, 1);
    chk("total_overrun", ov_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
